// File: rtl/uart_tx_buf.sv
// -----------------------------------------------------------------------------
// uart_tx_buf
//
// Byte FIFO with a send sequencer. It sits directly in front of uart_tx.
// Producers write bytes at any rate they like, up to the buffer depth. The
// sequencer hands the bytes to uart_tx one at a time. It raises a one-cycle
// send_en pulse with the byte on data_o, then waits for tx_done before it
// issues the next byte.
//
// Parameters
//   DEPTH    number of byte entries (power of two, >= 2)
//   AW       pointer width, log2(DEPTH)
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   wr_en     in   write strobe, one byte per cycle
//   wr_data   in   byte to enqueue
//   full      out  buffer holds DEPTH bytes
//   empty     out  buffer holds no bytes
//   level     out  current byte count, 0..DEPTH
//   overflow  out  one-cycle pulse for each dropped write
//   send_en   out  start pulse to uart_tx
//   data_o    out  byte presented to uart_tx
//   tx_done   in   completion pulse from uart_tx
//   busy      out  a byte is outstanding in uart_tx
// -----------------------------------------------------------------------------
module uart_tx_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          send_en,
    output logic [7:0]    data_o,
    input  logic          tx_done,
    output logic          busy
);

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Storage. It has no reset: after a reset the contents are unreachable,
    // because both pointers and the level counter restart from zero.
    logic [7:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          send_en_q, send_en_d;
    logic [7:0]    data_o_q, data_o_d;
    state_t        state_q, state_d;

    logic wr_accept;
    logic pop;

    // Status is decoded from the registered count. A write that arrives while
    // full is therefore rejected even if a pop frees a slot on the same edge.
    assign full      = (level_q == LEVEL_FULL);
    assign empty     = (level_q == '0);
    assign wr_accept = wr_en && !full;

    // ---------------- sequencer: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- sequencer: next state ----------------
    // A tx_done that arrives while send_en is still high is honoured. Only a
    // degenerate transmitter can produce that case. In IDLE, tx_done is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!empty)  state_d = ST_WAIT;
            ST_WAIT: if (tx_done) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // ---------------- sequencer: outputs ----------------
    always_comb begin
        pop  = 1'b0;
        busy = 1'b0;
        case (state_q)
            ST_IDLE: pop  = !empty;
            ST_WAIT: busy = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        send_en_d  = pop;
        data_o_d   = data_o_q;
        overflow_d = wr_en && full;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            data_o_d = mem[rd_ptr_q];
        end

        case ({wr_accept, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            send_en_q  <= 1'b0;
            data_o_q   <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            send_en_q  <= send_en_d;
            data_o_q   <= data_o_d;
        end
    end

    assign level    = level_q;
    assign overflow = overflow_q;
    assign send_en  = send_en_q;
    assign data_o   = data_o_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buf
//
// Scoreboard bench for uart_tx_buf. The stimulus pushes each byte that must
// eventually go out on send_en into exp_q. A monitor pops exp_q on every
// send_en and compares the popped byte with data_o. A small uart_tx
// stand-in answers every send_en with tx_done after a programmable delay.
// It can also withhold tx_done.
// -----------------------------------------------------------------------------
module tb_uart_tx_buf;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       send_en;
    logic [7:0] data_o;
    logic       tx_done;
    logic       busy;

    uart_tx_buf #(.DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .send_en  (send_en),
        .data_o   (data_o),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    // TX stand-in controls
    int tx_delay = 20;
    bit tx_hold  = 1'b0;
    int tx_cnt   = -1;

    // monitor state
    bit         mon_en     = 1'b0;
    bit         check_gap  = 1'b0;
    int         cyc        = 0;
    int         last_done  = -1;
    int         send_cnt   = 0;
    int         ovf_cnt    = 0;
    int         max_level  = 0;
    bit         prev_send  = 1'b0;
    bit         prev_done  = 1'b0;
    logic [7:0] exp_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Called at a negedge. Presents one byte for the next rising edge and
    // returns at the following negedge. Bytes that must be transmitted go
    // into the scoreboard.
    task automatic wr(input logic [7:0] b, input bit expect_sent);
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_sent) exp_q.push_back(b);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits until every expected byte has gone out and the DUT is quiet.
    task automatic drain(input string nm, input int max_cyc);
        int i;
        i = 0;
        while (!(exp_q.size() == 0 && busy == 1'b0 && empty == 1'b1) && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        chk(nm, (i >= max_cyc) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // uart_tx stand-in. It drives just after the rising edge and counts
    // down from the send_en that it sees.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tx_done = 1'b0;
            if (rst) begin
                tx_cnt = -1;
            end else begin
                if (send_en) tx_cnt = tx_delay;
                if (tx_cnt > 0 && !tx_hold) tx_cnt--;
                if (tx_cnt == 0 && !tx_hold) begin
                    tx_done = 1'b1;
                    tx_cnt  = -1;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en && !rst) begin
                if (send_en) begin
                    send_cnt++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_send: data_o %02h, expected no send_en", data_o);
                    end else begin
                        exp_b = exp_q.pop_front();
                        $display("tx byte %02h (expected %02h) at cycle %0d", data_o, exp_b, cyc);
                        chk("send_data", {24'd0, data_o}, {24'd0, exp_b});
                    end
                    chk("busy_with_send", {31'd0, busy}, 32'd1);
                    chk("send_en_gap", {31'd0, prev_send}, 32'd0);
                    if (check_gap && last_done >= 0)
                        chk("done_to_send", cyc - last_done, 32'd2);
                end
                if (prev_done) chk("busy_after_done", {31'd0, busy}, 32'd0);
                if (overflow) ovf_cnt++;
                if (int'(level) > max_level) max_level = int'(level);
                if (tx_done) last_done = cyc;
                prev_send = send_en;
                prev_done = tx_done;
            end else begin
                prev_send = 1'b0;
                prev_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int o0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'hEE;

        // ---- reset with wr_en toggling ----
        repeat (3) begin
            @(negedge clk);
            wr_en = ~wr_en;
        end
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_level",    {27'd0, level},    32'd0);
        chk("rst_empty",    {31'd0, empty},    32'd1);
        chk("rst_full",     {31'd0, full},     32'd0);
        chk("rst_send_en",  {31'd0, send_en},  32'd0);
        chk("rst_data_o",   {24'd0, data_o},   32'h00);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        idle(4);
        chk("rst_no_retained", {27'd0, level}, 32'd0);

        // ---- single byte ----
        tx_delay = 100;
        wr(8'hA5, 1'b1);
        chk("single_level1", {27'd0, level}, 32'd1);
        chk("single_empty0", {31'd0, empty}, 32'd0);
        @(negedge clk);
        chk("single_send_en", {31'd0, send_en}, 32'd1);
        chk("single_data",    {24'd0, data_o},  32'hA5);
        chk("single_busy",    {31'd0, busy},    32'd1);
        chk("single_level0",  {27'd0, level},   32'd0);
        drain("single_drain", 300);
        chk("single_done_busy",  {31'd0, busy},   32'd0);
        chk("single_done_level", {27'd0, level},  32'd0);
        chk("single_data_hold",  {24'd0, data_o}, 32'hA5);

        // ---- burst and ordering ----
        tx_delay  = 20;
        last_done = -1;
        check_gap = 1'b1;
        s0 = send_cnt;
        for (int i = 1; i <= 5; i++) wr(8'(i), 1'b1);
        drain("burst_drain", 500);
        check_gap = 1'b0;
        chk("burst_count", send_cnt - s0, 32'd5);

        // ---- full / overflow ----
        tx_hold   = 1'b1;
        max_level = 0;
        o0 = ovf_cnt;
        for (int i = 0; i < 17; i++) wr(8'h10 + 8'(i), 1'b1);
        chk("ovf_level_16", {27'd0, level},    32'd16);
        chk("ovf_full",     {31'd0, full},     32'd1);
        chk("ovf_first_out", {24'd0, data_o},  32'h10);
        chk("ovf_none_yet", {31'd0, overflow}, 32'd0);
        wr(8'h21, 1'b0);
        chk("ovf_pulse",    {31'd0, overflow}, 32'd1);
        chk("ovf_level_kept", {27'd0, level},  32'd16);
        @(negedge clk);
        chk("ovf_pulse_end", {31'd0, overflow}, 32'd0);
        chk("ovf_count",     ovf_cnt - o0,      32'd1);
        chk("ovf_peak",      max_level,         32'd16);
        tx_hold = 1'b0;
        drain("ovf_drain", 2000);

        // ---- wrap-around with fast tx_done ----
        tx_delay = 2;
        s0 = send_cnt;
        o0 = ovf_cnt;
        for (int i = 0; i < 40; i++) begin
            wr(8'h40 + 8'(i), 1'b1);
            idle(3);
        end
        drain("wrap_drain", 500);
        chk("wrap_count", send_cnt - s0, 32'd40);
        chk("wrap_no_ovf", ovf_cnt - o0, 32'd0);

        // ---- reset mid-operation ----
        tx_delay = 20;
        tx_hold  = 1'b1;
        wr(8'h80, 1'b1);
        for (int i = 1; i < 8; i++) wr(8'h80 + 8'(i), 1'b0);
        chk("mid_level7", {27'd0, level}, 32'd7);
        chk("mid_busy",   {31'd0, busy},  32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_level",   {27'd0, level},   32'd0);
        chk("mid_rst_busy",    {31'd0, busy},    32'd0);
        chk("mid_rst_send_en", {31'd0, send_en}, 32'd0);
        chk("mid_rst_empty",   {31'd0, empty},   32'd1);
        chk("mid_rst_data_o",  {24'd0, data_o},  32'h00);
        rst     = 1'b0;
        tx_hold = 1'b0;
        chk("mid_sb_flushed", exp_q.size(), 32'd0);
        wr(8'h3C, 1'b1);
        @(negedge clk);
        chk("mid_new_send", {31'd0, send_en}, 32'd1);
        drain("mid_drain", 300);
        chk("mid_final_data", {24'd0, data_o}, 32'h3C);

        idle(5);
        chk("end_scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
